// File: rtl/result_pipe_fwd.sv
// Purpose : carries execution results through a DEPTH-stage shift pipe to the RF write port and serves ra/rb forwarding lookups.
// Latency : in_pkt to rf_we is exactly DEPTH cycles; forwarding outputs are combinational from the stage registers.
// Backpressure: none; the pipe advances every cycle, and flush kills stages 1..FLUSH_DEPTH. Macro RESULT_PIPE_FWD_EN builds the forwarding search.
module result_pipe_fwd #(
    parameter int DEPTH       = 7,
    parameter int FLUSH_DEPTH = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [0:138]   in_pkt,
    input  logic           flush,
    input  logic [0:6]     src_a_addr,
    input  logic [0:6]     src_b_addr,
    output logic           fwd_a_hit,
    output logic [0:127]   fwd_a_data,
    output logic           fwd_a_stall,
    output logic           fwd_b_hit,
    output logic [0:127]   fwd_b_data,
    output logic           fwd_b_stall,
    output logic           rf_we,
    output logic [0:6]     rf_waddr,
    output logic [0:127]   rf_wdata
);

    // Stage k (1..DEPTH) holds one result; index 1 is the youngest.
    logic [0:127] r_data [1:DEPTH];
    logic [0:2]   r_lat  [1:DEPTH];
    logic         r_wr   [1:DEPTH];
    logic [0:6]   r_rt   [1:DEPTH];

    // Shift the pipe every cycle; flush clears the live bit of the young stages as they load.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= DEPTH; k++) begin
                r_data[k] <= '0;
                r_lat[k]  <= '0;
                r_wr[k]   <= 1'b0;
                r_rt[k]   <= '0;
            end
        end else begin
            r_data[1] <= in_pkt[0:127];
            r_lat[1]  <= in_pkt[128:130];
            r_wr[1]   <= in_pkt[131] && !flush;
            r_rt[1]   <= in_pkt[132:138];
            for (int k = 2; k <= DEPTH; k++) begin
                r_data[k] <= r_data[k-1];
                r_lat[k]  <= r_lat[k-1];
                r_wr[k]   <= r_wr[k-1] && !(flush && (k <= FLUSH_DEPTH));
                r_rt[k]   <= r_rt[k-1];
            end
        end
    end

    // Writeback comes straight from the oldest stage.
    assign rf_we    = r_wr[DEPTH];
    assign rf_waddr = r_rt[DEPTH];
    assign rf_wdata = r_data[DEPTH];

`ifdef RESULT_PIPE_FWD_EN

    // A result in stage k is usable once k reaches its latency; 0 acts as 1, oversize clamps to DEPTH.
    function automatic logic stage_ready(input int k, input logic [0:2] lat);
        int eff;
        eff = 32'(lat);
        if (eff == 0)     eff = 1;
        if (eff > DEPTH)  eff = DEPTH;
        return (k >= eff);
    endfunction

    // Youngest-match search for both sources: scan oldest to youngest so the lowest stage overwrites.
    always_comb begin
        fwd_a_hit   = 1'b0;
        fwd_a_stall = 1'b0;
        fwd_a_data  = '0;
        fwd_b_hit   = 1'b0;
        fwd_b_stall = 1'b0;
        fwd_b_data  = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (r_wr[k] && (r_rt[k] == src_a_addr)) begin
                fwd_a_hit   = stage_ready(k, r_lat[k]);
                fwd_a_stall = !stage_ready(k, r_lat[k]);
                fwd_a_data  = stage_ready(k, r_lat[k]) ? r_data[k] : '0;
            end
            if (r_wr[k] && (r_rt[k] == src_b_addr)) begin
                fwd_b_hit   = stage_ready(k, r_lat[k]);
                fwd_b_stall = !stage_ready(k, r_lat[k]);
                fwd_b_data  = stage_ready(k, r_lat[k]) ? r_data[k] : '0;
            end
        end
    end

`else

    // Without the search the issue stage waits for writeback, so every lookup reports no match.
    assign fwd_a_hit   = 1'b0;
    assign fwd_a_stall = 1'b0;
    assign fwd_a_data  = '0;
    assign fwd_b_hit   = 1'b0;
    assign fwd_b_stall = 1'b0;
    assign fwd_b_data  = '0;

    logic w_unused;

    // Fold the lookup-only inputs and latency fields into a sink so they are not left dangling.
    always_comb begin
        w_unused = ^{src_a_addr, src_b_addr};
        for (int k = 1; k <= DEPTH; k++) begin
            w_unused = w_unused ^ (^r_lat[k]);
        end
    end

`endif

endmodule

// File: tb/tb_result_pipe_fwd.sv
// Bench for result_pipe_fwd: writeback scoreboard plus scenario tasks for forwarding, latency, flush and reset.
// Forwarding expectations collapse to zero when RESULT_PIPE_FWD_EN is not defined.
module tb_result_pipe_fwd;

    localparam int DEPTH       = 7;
    localparam int FLUSH_DEPTH = 3;
`ifdef RESULT_PIPE_FWD_EN
    localparam bit FWD_ON = 1'b1;
`else
    localparam bit FWD_ON = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [0:138]   in_pkt;
    logic           flush;
    logic [0:6]     src_a_addr;
    logic [0:6]     src_b_addr;
    logic           fwd_a_hit;
    logic [0:127]   fwd_a_data;
    logic           fwd_a_stall;
    logic           fwd_b_hit;
    logic [0:127]   fwd_b_data;
    logic           fwd_b_stall;
    logic           rf_we;
    logic [0:6]     rf_waddr;
    logic [0:127]   rf_wdata;

    typedef struct {
        int           due;
        logic [0:6]   addr;
        logic [0:127] data;
    } exp_t;

    exp_t sb_q[$];
    int   cyc      = 0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   wr_seen  = 0;
    bit   mon_en   = 1'b0;

    result_pipe_fwd #(.DEPTH(DEPTH), .FLUSH_DEPTH(FLUSH_DEPTH)) dut (
        .clk(clk), .reset(reset), .in_pkt(in_pkt), .flush(flush),
        .src_a_addr(src_a_addr), .src_b_addr(src_b_addr),
        .fwd_a_hit(fwd_a_hit), .fwd_a_data(fwd_a_data), .fwd_a_stall(fwd_a_stall),
        .fwd_b_hit(fwd_b_hit), .fwd_b_data(fwd_b_data), .fwd_b_stall(fwd_b_stall),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writeback monitor: each cycle rf_we must match exactly what the scoreboard has due.
    always @(negedge clk) begin
        if (mon_en) begin
            while (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_missing: cycle %0d, write to r%0d due at %0d never seen", cyc, sb_q[0].addr, sb_q[0].due);
                void'(sb_q.pop_front());
            end
            if (rf_we === 1'b1) wr_seen++;
            n_checks++;
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                if (rf_we !== 1'b1 || rf_waddr !== sb_q[0].addr || rf_wdata !== sb_q[0].data) begin
                    n_fail++;
                    $display("FAIL wb_data: cycle %0d got we=%b addr=%0d data=%h, expected we=1 addr=%0d data=%h",
                             cyc, rf_we, rf_waddr, rf_wdata, sb_q[0].addr, sb_q[0].data);
                end
                void'(sb_q.pop_front());
            end else if (rf_we !== 1'b0) begin
                n_fail++;
                $display("FAIL wb_spurious: cycle %0d got we=%b addr=%0d, expected we=0", cyc, rf_we, rf_waddr);
            end
        end
    end

    task automatic drive(input logic [0:127] d, input logic [0:2] l, input logic w, input logic [0:6] rt);
        exp_t e;
        in_pkt = {d, l, w, rt};
        if (w) begin
            e.due  = cyc + DEPTH;
            e.addr = rt;
            e.data = d;
            sb_q.push_back(e);
        end
    endtask

    task automatic purge_after(input int lim);
        for (int i = sb_q.size() - 1; i >= 0; i--)
            if (sb_q[i].due > lim) sb_q.delete(i);
    endtask

    task automatic test_reset;
        in_pkt     = {128'h0, 3'd0, 1'b1, 7'd5};
        src_a_addr = 7'd5;
        src_b_addr = 7'd5;
        reset      = 1'b1;
        flush      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            mon_en = 1'b1;
            n_checks++;
            if ({rf_we, fwd_a_hit, fwd_a_stall, fwd_b_hit, fwd_b_stall} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset_ctrl[%0d]: got we/ha/sa/hb/sb=%b expected 00000", i,
                         {rf_we, fwd_a_hit, fwd_a_stall, fwd_b_hit, fwd_b_stall});
            end
        end
        reset  = 1'b0;
        in_pkt = '0;
        @(negedge clk);
        n_checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_rf: got we=%b addr=%0d data=%h expected all zero", rf_we, rf_waddr, rf_wdata);
        end
        n_checks++;
        if ({fwd_a_hit, fwd_a_stall, fwd_a_data, fwd_b_hit, fwd_b_stall, fwd_b_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_fwd: got ha=%b sa=%b da=%h expected zeros", fwd_a_hit, fwd_a_stall, fwd_a_data);
        end
    endtask

    task automatic test_latency;
        logic [0:127] ed;
        src_a_addr = 7'd3;
        src_b_addr = 7'd4;
        drive(128'h1, 3'd2, 1'b1, 7'd3);
        @(negedge clk);
        drive('0, 3'd0, 1'b0, 7'd0);
        n_checks++;
        if (fwd_a_stall !== FWD_ON || fwd_a_hit !== 1'b0 || fwd_a_data !== '0) begin
            n_fail++;
            $display("FAIL lat_stage1: got hit=%b stall=%b data=%h expected hit=0 stall=%b data=0",
                     fwd_a_hit, fwd_a_stall, fwd_a_data, FWD_ON);
        end
        ed = FWD_ON ? 128'h1 : 128'h0;
        for (int k = 2; k <= DEPTH; k++) begin
            @(negedge clk);
            n_checks++;
            if (fwd_a_hit !== FWD_ON || fwd_a_stall !== 1'b0 || fwd_a_data !== ed) begin
                n_fail++;
                $display("FAIL lat_stage%0d: got hit=%b stall=%b data=%h expected hit=%b stall=0 data=%h",
                         k, fwd_a_hit, fwd_a_stall, fwd_a_data, FWD_ON, ed);
            end
            n_checks++;
            if ({fwd_b_hit, fwd_b_stall, fwd_b_data} !== '0) begin
                n_fail++;
                $display("FAIL lat_nomatch_b: got hit=%b stall=%b expected 0 0", fwd_b_hit, fwd_b_stall);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({fwd_a_hit, fwd_a_stall, fwd_a_data} !== '0) begin
            n_fail++;
            $display("FAIL lat_retired: got hit=%b stall=%b data=%h expected all zero", fwd_a_hit, fwd_a_stall, fwd_a_data);
        end
    endtask

    task automatic test_lat_bounds;
        logic [0:127] ed;
        // lat=0 behaves as 1, and r0 is an ordinary register; both sources on the same rt.
        src_a_addr = 7'd0;
        src_b_addr = 7'd0;
        drive(128'h55, 3'd0, 1'b1, 7'd0);
        @(negedge clk);
        ed = FWD_ON ? 128'h55 : 128'h0;
        n_checks++;
        if (fwd_a_hit !== FWD_ON || fwd_a_stall !== 1'b0 || fwd_a_data !== ed) begin
            n_fail++;
            $display("FAIL lat0_a: got hit=%b stall=%b data=%h expected hit=%b data=%h", fwd_a_hit, fwd_a_stall, fwd_a_data, FWD_ON, ed);
        end
        n_checks++;
        if (fwd_b_hit !== FWD_ON || fwd_b_stall !== 1'b0 || fwd_b_data !== ed) begin
            n_fail++;
            $display("FAIL lat0_b: got hit=%b stall=%b data=%h expected hit=%b data=%h", fwd_b_hit, fwd_b_stall, fwd_b_data, FWD_ON, ed);
        end
        // lat=7 stays pending until the last stage.
        src_a_addr = 7'd9;
        drive(128'h77, 3'd7, 1'b1, 7'd9);
        @(negedge clk);
        drive('0, 3'd0, 1'b0, 7'd0);
        for (int k = 1; k < DEPTH; k++) begin
            n_checks++;
            if (fwd_a_stall !== FWD_ON || fwd_a_hit !== 1'b0) begin
                n_fail++;
                $display("FAIL lat7_pending%0d: got hit=%b stall=%b expected hit=0 stall=%b", k, fwd_a_hit, fwd_a_stall, FWD_ON);
            end
            @(negedge clk);
        end
        ed = FWD_ON ? 128'h77 : 128'h0;
        n_checks++;
        if (fwd_a_hit !== FWD_ON || fwd_a_stall !== 1'b0 || fwd_a_data !== ed) begin
            n_fail++;
            $display("FAIL lat7_last: got hit=%b stall=%b data=%h expected hit=%b data=%h", fwd_a_hit, fwd_a_stall, fwd_a_data, FWD_ON, ed);
        end
    endtask

    task automatic test_youngest;
        logic [0:127] ed;
        src_a_addr = 7'd100;
        src_b_addr = 7'd8;
        drive(128'hAA, 3'd1, 1'b1, 7'd8);
        @(negedge clk);
        ed = FWD_ON ? 128'hAA : 128'h0;
        n_checks++;
        if (fwd_b_hit !== FWD_ON || fwd_b_data !== ed) begin
            n_fail++;
            $display("FAIL young_first: got hit=%b data=%h expected hit=%b data=%h", fwd_b_hit, fwd_b_data, FWD_ON, ed);
        end
        drive(128'hBB, 3'd4, 1'b1, 7'd8);
        @(negedge clk);
        drive('0, 3'd0, 1'b0, 7'd0);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (fwd_b_stall !== FWD_ON || fwd_b_hit !== 1'b0 || fwd_b_data !== '0) begin
                n_fail++;
                $display("FAIL young_stall%0d: got hit=%b stall=%b data=%h expected hit=0 stall=%b data=0",
                         i, fwd_b_hit, fwd_b_stall, fwd_b_data, FWD_ON);
            end
            @(negedge clk);
        end
        ed = FWD_ON ? 128'hBB : 128'h0;
        n_checks++;
        if (fwd_b_hit !== FWD_ON || fwd_b_stall !== 1'b0 || fwd_b_data !== ed) begin
            n_fail++;
            $display("FAIL young_ready: got hit=%b stall=%b data=%h expected hit=%b data=%h", fwd_b_hit, fwd_b_stall, fwd_b_data, FWD_ON, ed);
        end
        n_checks++;
        if ({fwd_a_hit, fwd_a_stall} !== 2'b00) begin
            n_fail++;
            $display("FAIL young_other_src: got hit=%b stall=%b expected 0 0", fwd_a_hit, fwd_a_stall);
        end
    endtask

    task automatic test_flush;
        logic [0:127] ed;
        repeat (DEPTH + 1) @(negedge clk);
        for (int i = 1; i <= 7; i++) begin
            drive(128'h100 + 128'(i), 3'd1, 1'b1, 7'(i));
            @(negedge clk);
        end
        src_b_addr = 7'd7;
        src_a_addr = 7'd6;
        drive(128'h109, 3'd1, 1'b1, 7'd9);
        flush = 1'b1;
        purge_after(cyc + DEPTH - FLUSH_DEPTH);
        #1;
        ed = FWD_ON ? 128'h107 : 128'h0;
        n_checks++;
        if (fwd_b_hit !== FWD_ON || fwd_b_data !== ed) begin
            n_fail++;
            $display("FAIL flush_comb: got hit=%b data=%h expected hit=%b data=%h", fwd_b_hit, fwd_b_data, FWD_ON, ed);
        end
        @(negedge clk);
        flush = 1'b0;
        drive('0, 3'd0, 1'b0, 7'd0);
        n_checks++;
        if ({fwd_a_hit, fwd_a_stall, fwd_a_data} !== '0) begin
            n_fail++;
            $display("FAIL flush_killed: got hit=%b stall=%b data=%h expected all zero", fwd_a_hit, fwd_a_stall, fwd_a_data);
        end
        src_b_addr = 7'd5;
        #1;
        ed = FWD_ON ? 128'h105 : 128'h0;
        n_checks++;
        if (fwd_b_hit !== FWD_ON || fwd_b_data !== ed) begin
            n_fail++;
            $display("FAIL flush_survivor: got hit=%b data=%h expected hit=%b data=%h", fwd_b_hit, fwd_b_data, FWD_ON, ed);
        end
    endtask

    task automatic test_reset_mid;
        int seen0;
        repeat (DEPTH + 1) @(negedge clk);
        src_a_addr = 7'd41;
        for (int i = 0; i < 4; i++) begin
            drive(128'h200 + 128'(i), 3'd1, 1'b1, 7'(40 + i));
            @(negedge clk);
        end
        drive('0, 3'd0, 1'b0, 7'd0);
        reset = 1'b1;
        flush = 1'b1;
        purge_after(cyc);
        seen0 = wr_seen;
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;
        n_checks++;
        if ({fwd_a_hit, fwd_a_stall, fwd_a_data} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_fwd: got hit=%b stall=%b expected 0 0", fwd_a_hit, fwd_a_stall);
        end
        repeat (DEPTH + 3) @(negedge clk);
        n_checks++;
        if (wr_seen != seen0) begin
            n_fail++;
            $display("FAIL rstmid_writes: got %0d rf_we pulses after reset, expected 0", wr_seen - seen0);
        end
    endtask

    initial begin
        reset      = 1'b1;
        flush      = 1'b0;
        in_pkt     = '0;
        src_a_addr = '0;
        src_b_addr = '0;
        test_reset;
        test_latency;
        test_lat_bounds;
        test_youngest;
        test_flush;
        test_reset_mid;
        repeat (DEPTH + 2) @(negedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d writes still pending, expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_pipe_fwd.md
Name: result_pipe_fwd

Overview:
- Sits directly downstream of the SimpleFixed1 execution unit.
- Takes the unit's 139-bit result bundle each cycle and carries it through a fixed-depth shift pipeline to the register-file write port.
- While results are in flight, serves two forwarding lookups (ra, rb source addresses) so the issue stage can bypass the register file or stall.
- All vectors use big-endian bit order [0:N-1], matching the execution units.

Parameters:
- DEPTH, 7, number of pipeline stages between execution output and register-file write (stages 1..DEPTH).
- FLUSH_DEPTH, 3, youngest stages (1..FLUSH_DEPTH) killed by flush.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_pkt  in  [0:138]  execution bundle: [0:127] data, [128:130] ready latency, [131] wr, [132:138] rt address
- flush  in  1  kill the in-flight younger results
- src_a_addr  in  [0:6]  ra source register for forwarding lookup
- src_b_addr  in  [0:6]  rb source register for forwarding lookup
- fwd_a_hit  out  1  a ready, youngest match exists for src_a
- fwd_a_data  out  [0:127]  forwarded data for src_a
- fwd_a_stall  out  1  youngest match for src_a exists but is not ready
- fwd_b_hit, fwd_b_data, fwd_b_stall  out  1/[0:127]/1  same functions for src_b
- rf_we  out  1  register-file write enable
- rf_waddr  out  [0:6]  register-file write address
- rf_wdata  out  [0:127]  register-file write data

Behaviour:
- Decided: one clock, clk; reset is synchronous and active-high, named reset.

Stage registers:
- Each stage k holds data, lat, wr and rt.
- On each rising clk, stage 1 captures in_pkt and stage k captures stage k-1 for k = 2..DEPTH.
- A stage is live when its wr bit is 1.

Latency:
- A live stage k is ready when k >= lat.
- lat = 0 is treated as 1.
- lat > DEPTH is treated as DEPTH.

Writeback:
- rf_we, rf_waddr and rf_wdata are driven combinationally from stage DEPTH.
- rf_we = stage DEPTH wr.
- The total in_pkt-to-rf_we latency is exactly DEPTH cycles.
- Register 0 is an ordinary register; it gets no special treatment.

Forwarding (per source):
- Search stages 1..DEPTH for live entries with rt == src address.
- The youngest match (lowest k) wins.
- If the youngest match is ready: hit = 1, data = its data, stall = 0.
- If the youngest match is not ready: hit = 0, stall = 1, data = 0. Older ready matches are never used.
- If there is no match: hit = 0, stall = 0, data = 0.
- All forwarding outputs are combinational from the stage registers and the src addresses.
- in_pkt itself (stage 0) is never searched.
- The stage-DEPTH entry is searched in the same cycle it is being written, so the caller sees consistent data whether it reads the RF next cycle or forwards now.

Flush:
- At the rising edge where flush = 1:
  - in_pkt is captured with wr forced to 0.
  - Stages 2..FLUSH_DEPTH receive their shifted-in contents with wr forced to 0.
  - Stages FLUSH_DEPTH+1..DEPTH shift normally.
- Flush has no combinational effect on the current-cycle forwarding or writeback outputs.

Reset:
- All stage wr bits are 0, and data, lat and rt are 0.
- Consequently rf_we = 0, rf_waddr = 0, rf_wdata = 0 and all fwd outputs = 0 in the cycle after reset.
- Reset asserted mid-stream discards all in-flight results; no write occurs on the reset edge or in the following cycle.
- Reset has priority over flush.

Boundary cases:
- Back-to-back writes to the same rt both retire in order; forwarding always returns the younger.
- Both sources naming the same rt produce identical a/b results.

Optional Feature:
- Macro: RESULT_PIPE_FWD_EN.
- Defined: the forwarding search logic is built as described above.
- Not defined: no search logic is built; fwd_*_hit = 0, fwd_*_data = 0 and fwd_*_stall = 0 constantly.
- The issue stage then waits for writeback. Writeback behaviour is identical in both builds.

Test Plan:
- Reset sequence: reset = 1 for 2 cycles with in_pkt wr = 1, rt = 5 -> rf_we = 0 throughout and for the cycle after; all fwd outputs 0.
- Latency: inject data = 128'h1, lat = 2, wr = 1, rt = 3; hold src_a = 3 and wr = 0 afterwards.
  - Cycle +1 (stage 1): stall_a = 1.
  - Cycle +2: hit_a = 1, data_a = 1.
  - Cycle +7: rf_we = 1, waddr = 3, wdata = 1.
  - Cycle +8: no hit.
- Youngest-wins: inject rt = 8 data = 0xAA lat = 1, then next cycle rt = 8 data = 0xBB lat = 4, with src_b = 8.
  - After the second capture: stall_b = 1 (the ready older match is ignored).
  - 3 cycles later: hit_b = 1, data = 0xBB.
  - The two rf writes occur on consecutive cycles, 0xAA then 0xBB.
- Flush: fill stages with rt = 1..7 (one per cycle, all wr = 1), then assert flush for one edge together with a new rt = 9 packet.
  - Writebacks for the packets that were in stages 1..FLUSH_DEPTH-1 and for rt = 9 never occur.
  - The packets from stages FLUSH_DEPTH..DEPTH still write back in order.
- Reset mid-stream: 4 live packets in flight, reset for 1 cycle -> zero further rf_we pulses.
- Macro off (RESULT_PIPE_FWD_EN undefined): rerun the latency test -> fwd outputs stay 0 and rf_we still pulses at cycle +7 with waddr = 3, wdata = 1.
